// File: rtl/oe_fifo_buffer_if.sv
// Bus-side signal bundle for oe_fifo_buffer: producer controls, the
// tri-state result bus and the queue status flags.
interface oe_fifo_buffer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] in;
    logic             wr_en;
    logic             rd_en;
    logic             OE;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             ovf;
    logic             unf;

    // Producer / bus-arbiter side.
    modport master (
        output in, wr_en, rd_en, OE,
        input  out, valid, full, empty, count, ovf, unf
    );

    // Buffer side.
    modport slave (
        input  in, wr_en, rd_en, OE,
        output out, valid, full, empty, count, ovf, unf
    );
endinterface

// File: rtl/oe_fifo_buffer.sv
// First-word-fall-through queue of DEPTH words whose head word is driven
// onto a shared tri-state bus only while OE is high.
module oe_fifo_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    oe_fifo_buffer_if.slave  bus
);
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_drive;

    // Status decodes and accept rules from the registered count.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == FULL_COUNT);
        w_pop_ok  = bus.rd_en && !w_empty;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        w_push_ok = bus.wr_en && (!w_full || w_pop_ok);
        w_drive   = bus.OE && !w_empty;
    end

    // Storage write; contents survive reset, a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.in;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.wr_en && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Output drive: head word only when enabled and non-empty, else released.
    assign bus.out   = w_drive ? r_mem[r_rd_ptr] : {WIDTH{1'bz}};
    assign bus.valid = !w_empty;
    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign bus.count = r_count;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;
endmodule

// File: tb/tb_oe_fifo_buffer.sv
// Directed self-checking bench for oe_fifo_buffer (WIDTH=32, DEPTH=4).
module tb_oe_fifo_buffer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] zv;

    oe_fifo_buffer_if #(.WIDTH(32), .DEPTH(4)) bus ();

    oe_fifo_buffer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.in    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.OE = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.OE = 1'b1;
        step();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (bus.out !== zv) begin errors++; $display("FAIL reset_out: got %h want Z", bus.out); end
        checks++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", bus.ovf, bus.unf); end
    endtask

    task automatic test_oe_gating();
        bus.in = 32'h1;
        bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.out !== 32'h1) begin errors++; $display("FAIL oe_on_out: got %h want 00000001", bus.out); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL oe_count: got %0d want 1", bus.count); end
        bus.OE = 1'b0;
        #1;
        checks++; if (bus.out !== zv) begin errors++; $display("FAIL oe_off_out: got %h want Z", bus.out); end
        step();
        checks++; if (bus.count !== 3'd1 || bus.valid !== 1'b1) begin errors++; $display("FAIL oe_off_count: got %0d valid=%b want 1 1", bus.count, bus.valid); end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        bus.OE = 1'b1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL oe_pop_while_off: got empty=%b want 1", bus.empty); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_word;
        for (int i = 0; i < 4; i++) begin
            bus.in = 32'hA0 + 32'(i);
            bus.wr_en = 1'b1;
            step();
        end
        bus.wr_en = 1'b0;
        checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL fill_full: got full=%b count=%0d want 1 4", bus.full, bus.count); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b want 0", bus.ovf); end
        bus.in = 32'hFF;
        bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.ovf); end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", bus.count); end
        for (int i = 0; i < 4; i++) begin
            exp_word = 32'hA0 + 32'(i);
            checks++; if (bus.out !== exp_word) begin errors++; $display("FAIL drain_A%0d: got %h want %h", i, bus.out, exp_word); end
            bus.rd_en = 1'b1;
            step();
        end
        bus.rd_en = 1'b0;
        checks++; if (bus.empty !== 1'b1 || bus.out !== zv) begin errors++; $display("FAIL drain_end: got empty=%b out=%h want 1 Z", bus.empty, bus.out); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_q [4];
        exp_q[0] = 32'hB1; exp_q[1] = 32'hB2; exp_q[2] = 32'hB3; exp_q[3] = 32'hC0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in = 32'hB0 + 32'(i);
            bus.wr_en = 1'b1;
            step();
        end
        bus.in = 32'hC0;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL simul_count: got %0d want 4", bus.count); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b want 0", bus.ovf); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out !== exp_q[i]) begin errors++; $display("FAIL simul_drain%0d: got %h want %h", i, bus.out, exp_q[i]); end
            bus.rd_en = 1'b1;
            step();
        end
        bus.rd_en = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL simul_empty: got %0d want 0", bus.count); end
    endtask

    task automatic test_underflow_wrap();
        logic [31:0] exp_word;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.unf !== 1'b1 || bus.count !== 3'd0) begin errors++; $display("FAIL unf_set: got unf=%b count=%0d want 1 0", bus.unf, bus.count); end
        for (int i = 0; i < 6; i++) begin
            exp_word = 32'hD0 + 32'(i);
            bus.in = exp_word;
            bus.wr_en = 1'b1;
            step();
            bus.wr_en = 1'b0;
            checks++; if (bus.out !== exp_word || bus.count !== 3'd1) begin errors++; $display("FAIL wrap_D%0d: got out=%h count=%0d want %h 1", i, bus.out, bus.count, exp_word); end
            bus.rd_en = 1'b1;
            step();
            bus.rd_en = 1'b0;
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_end_empty: got %b want 1", bus.empty); end
        // Push and pop together on empty: push only, no bypass.
        bus.in = 32'hE0;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        #1;
        checks++; if (bus.out !== zv) begin errors++; $display("FAIL no_bypass: got %h want Z", bus.out); end
        step();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        checks++; if (bus.count !== 3'd1 || bus.out !== 32'hE0) begin errors++; $display("FAIL empty_pushpop: got count=%0d out=%h want 1 000000e0", bus.count, bus.out); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            bus.in = 32'hF0 + 32'(i);
            bus.wr_en = 1'b1;
            step();
        end
        bus.wr_en = 1'b0;
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mid_precount: got %0d want 3", bus.count); end
        bus.in = 32'hEE;
        bus.wr_en = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.wr_en = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL mid_count: got count=%0d empty=%b want 0 1", bus.count, bus.empty); end
        checks++; if (bus.out !== zv) begin errors++; $display("FAIL mid_out: got %h want Z", bus.out); end
        checks++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin errors++; $display("FAIL mid_flags: got ovf=%b unf=%b want 0 0", bus.ovf, bus.unf); end
        step();
        checks++; if (bus.count !== 3'd0 || bus.valid !== 1'b0) begin errors++; $display("FAIL mid_discard: got count=%0d valid=%b want 0 0", bus.count, bus.valid); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        zv = 'z;
        rst = 1'b1;
        bus.OE = 1'b0;
        idle_inputs();
        test_reset();
        test_oe_gating();
        test_fill_drain();
        test_simultaneous();
        test_underflow_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
